// File: rtl/fifo_pkg.sv
// Shared FIFO defaults and flag helpers.
// Reused by fifo_lvl, uart_rx and uart_tx.
package fifo_pkg;

    localparam int FIFO_B  = 8;
    localparam int FIFO_W  = 4;
    localparam int FIFO_AE = 1;
    localparam int FIFO_AF = 2**FIFO_W - 1;

    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

    typedef struct packed {
        logic empty;
        logic full;
        logic aempty;
        logic afull;
    } fifo_flags_t;

    localparam fifo_flags_t FLAGS_RST = '{
        empty:  1'b1,
        full:   1'b0,
        aempty: 1'b1,
        afull:  1'b0
    };

    function automatic fifo_flags_t lvl_flags(
        input int lvl,
        input int depth,
        input int ae,
        input int af
    );
        fifo_flags_t f;
        f.empty  = (lvl == 0);
        f.full   = (lvl == depth);
        f.aempty = (lvl <= ae);
        f.afull  = (lvl >= af);
        return f;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// FIFO storage: one write port, asynchronous read.
// Contents are deliberately never reset.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int B = FIFO_B,
    parameter int W = FIFO_W
) (
    input  logic         clk,
    input  logic         we_i,
    input  logic [W-1:0] w_addr_i,
    input  logic [B-1:0] w_data_i,
    input  logic [W-1:0] r_addr_i,
    output logic [B-1:0] r_data_o
);

    logic [B-1:0] mem_q [2**W];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[w_addr_i] <= w_data_i;
        end
    end

    assign r_data_o = mem_q[r_addr_i];

endmodule

// File: rtl/fifo_lvl.sv
// Show-ahead FIFO with registered level, threshold
// flags and sticky overflow/underflow indicators.
module fifo_lvl
    import fifo_pkg::*;
#(
    parameter int B  = FIFO_B,
    parameter int W  = FIFO_W,
    parameter int AE = FIFO_AE,
    parameter int AF = 2**W - 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         rd,
    input  logic         wr,
    input  logic [B-1:0] w_data,
    output logic [B-1:0] r_data,
    output logic         empty,
    output logic         full,
    output logic         almost_empty,
    output logic         almost_full,
    output logic [W:0]   level,
    output logic         overflow,
    output logic         underflow
);

    localparam int         DEPTH   = 2**W;
    localparam logic [W-1:0] PTR_ONE = 1;
    localparam logic [W:0]   LVL_ONE = 1;

    logic [W-1:0] wptr_q, wptr_d;
    logic [W-1:0] rptr_q, rptr_d;
    logic [W:0]   level_q, level_d;
    fifo_flags_t  flags_q, flags_d;
    logic         ovf_q, ovf_d;
    logic         unf_q, unf_d;

    logic         rd_ok;
    logic         wr_ok;
    logic         we;
    fifo_op_e     op;

    // A full FIFO still takes a write when a pop frees a slot.
    assign rd_ok = rd & ~flags_q.empty;
    assign wr_ok = wr & (~flags_q.full | rd_ok);
    assign op    = fifo_op_e'({rd_ok, wr_ok});
    assign we    = wr_ok & ~clr;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;

        if (clr) begin
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
        end else begin
            unique case (op)
                OP_PUSH: begin
                    wptr_d  = wptr_q + PTR_ONE;
                    level_d = level_q + LVL_ONE;
                end
                OP_POP: begin
                    rptr_d  = rptr_q + PTR_ONE;
                    level_d = level_q - LVL_ONE;
                end
                OP_BOTH: begin
                    wptr_d = wptr_q + PTR_ONE;
                    rptr_d = rptr_q + PTR_ONE;
                end
                default: begin
                    level_d = level_q;
                end
            endcase

            if (wr && !wr_ok) begin
                ovf_d = 1'b1;
            end
            if (rd && flags_q.empty) begin
                unf_d = 1'b1;
            end
        end

        flags_d = lvl_flags(int'(level_d), DEPTH, AE, AF);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            flags_q <= FLAGS_RST;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            flags_q <= flags_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    fifo_ram #(
        .B (B),
        .W (W)
    ) u_ram (
        .clk      (clk),
        .we_i     (we),
        .w_addr_i (wptr_q),
        .w_data_i (w_data),
        .r_addr_i (rptr_q),
        .r_data_o (r_data)
    );

    assign empty        = flags_q.empty;
    assign full         = flags_q.full;
    assign almost_empty = flags_q.aempty;
    assign almost_full  = flags_q.afull;
    assign level        = level_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule

// File: tb/tb_fifo_lvl.sv
// Self-checking bench for fifo_lvl against a
// queue-based reference model.
module tb_fifo_lvl;

    localparam int DEPTH = 16;
    localparam int AE    = 1;
    localparam int AF    = 15;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       clr = 1'b0;
    logic       rd = 1'b0;
    logic       wr = 1'b0;
    logic [7:0] w_data = '0;
    logic [7:0] r_data;
    logic       empty, full;
    logic       almost_empty, almost_full;
    logic [4:0] level;
    logic       overflow, underflow;

    int n_chk = 0;
    int n_err = 0;

    logic [7:0] mq [$];
    logic       m_ovf = 1'b0;
    logic       m_unf = 1'b0;

    fifo_lvl dut (
        .clk          (clk),
        .reset        (reset),
        .clr          (clr),
        .rd           (rd),
        .wr           (wr),
        .w_data       (w_data),
        .r_data       (r_data),
        .empty        (empty),
        .full         (full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .level        (level),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_state();
        int sz;
        sz = mq.size();
        check("level", 32'(level), 32'(sz));
        check("empty", 32'(empty), 32'(sz == 0));
        check("full", 32'(full), 32'(sz == DEPTH));
        check("aempty", 32'(almost_empty), 32'(sz <= AE));
        check("afull", 32'(almost_full), 32'(sz >= AF));
        check("ovf", 32'(overflow), 32'(m_ovf));
        check("unf", 32'(underflow), 32'(m_unf));
        if (sz > 0) begin
            check("head", 32'(r_data), 32'(mq[0]));
        end
    endtask

    task automatic step(
        input logic       r,
        input logic       w,
        input logic [7:0] d,
        input logic       c
    );
        int   sz;
        logic ra, wa;
        rd = r;
        wr = w;
        w_data = d;
        clr = c;
        #1;
        sz = mq.size();
        if (c) begin
            mq.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            ra = r && (sz > 0);
            wa = w && ((sz < DEPTH) || ra);
            if (ra) check("rdata", 32'(r_data), 32'(mq[0]));
            if (w && !wa) m_ovf = 1'b1;
            if (r && (sz == 0)) m_unf = 1'b1;
            if (ra) void'(mq.pop_front());
            if (wa) mq.push_back(d);
        end
        @(posedge clk);
        #1;
        rd = 1'b0;
        wr = 1'b0;
        clr = 1'b0;
        check_state();
    endtask

    initial begin
        #12;
        check("rst_level", 32'(level), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_aempty", 32'(almost_empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_afull", 32'(almost_full), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_unf", 32'(underflow), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // fill
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, 8'(i), 1'b0);
            if (i == 14) begin
                check("fill_af15", 32'(almost_full), 32'd1);
                check("fill_nf15", 32'(full), 32'd0);
            end
        end
        check("fill_full", 32'(full), 32'd1);
        check("fill_lvl", 32'(level), 32'd16);

        // overflow then drain
        step(1'b0, 1'b1, 8'hAA, 1'b0);
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_lvl", 32'(level), 32'd16);
        for (int i = 0; i < 16; i++) begin
            check("drain_val", 32'(r_data), 32'(i));
            step(1'b1, 1'b0, 8'h00, 1'b0);
        end
        check("drain_empty", 32'(empty), 32'd1);

        // underflow with simultaneous write
        step(1'b1, 1'b1, 8'h55, 1'b0);
        check("unf_lvl", 32'(level), 32'd1);
        check("unf_set", 32'(underflow), 32'd1);
        check("unf_data", 32'(r_data), 32'h55);

        // full pass-through across pointer wrap
        step(1'b0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, 8'(8'h80 + i), 1'b0);
        end
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, 8'(8'hC0 + i), 1'b0);
            check("pt_lvl", 32'(level), 32'd16);
            check("pt_ovf", 32'(overflow), 32'd0);
        end
        while (mq.size() > 0) begin
            step(1'b1, 1'b0, 8'h00, 1'b0);
        end

        // clr at level 5 with rd/wr asserted
        step(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 8'(8'h10 + i), 1'b0);
        end
        step(1'b1, 1'b1, 8'hEE, 1'b1);
        check("clr_lvl", 32'(level), 32'd0);
        check("clr_empty", 32'(empty), 32'd1);
        check("clr_unf", 32'(underflow), 32'd0);
        step(1'b0, 1'b1, 8'h21, 1'b0);
        check("clr_head", 32'(r_data), 32'h21);
        step(1'b1, 1'b0, 8'h00, 1'b0);

        // async reset at level 9
        for (int i = 0; i < 9; i++) begin
            step(1'b0, 1'b1, 8'(8'h40 + i), 1'b0);
        end
        #2;
        reset = 1'b1;
        #1;
        mq.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        check("ar_level", 32'(level), 32'd0);
        check("ar_empty", 32'(empty), 32'd1);
        check("ar_aempty", 32'(almost_empty), 32'd1);
        check_state();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        step(1'b0, 1'b1, 8'h3C, 1'b0);
        check("ar_head", 32'(r_data), 32'h3C);
        step(1'b1, 1'b0, 8'h00, 1'b0);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            logic r, w, c;
            int   bias;
            bias = (i / 100) % 2 == 0 ? 70 : 30;
            w = ($urandom_range(0, 99) < bias);
            r = ($urandom_range(0, 99) < 100 - bias);
            c = ($urandom_range(0, 79) == 0);
            step(r, w, 8'($urandom_range(0, 255)), c);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule
